// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (C) and loader (L) ports.
// Optional loader bus lock is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
`ifdef DMEM_ARB_LOCK_EN
    ,
    parameter int LOCK_MAX   = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_ack,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  c_stall,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    output logic                  l_ack,
    output logic [DATA_WIDTH-1:0] l_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic                  l_lock,
`endif
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic                  rr_q, rr_d;   // 1 = L favoured on a tie
    logic                  grant_l;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_WIDTH-1:0] l_rdata_q, l_rdata_d;

`ifdef DMEM_ARB_LOCK_EN
    localparam int LockW = $clog2(LOCK_MAX + 1);
    logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_hit;
`endif

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        rr_d      = rr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        l_rdata_d = l_rdata_q;
        grant_l   = 1'b0;
        c_ack     = 1'b0;
        l_ack     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
        lock_hit   = l_req & l_lock & owner_q & (lock_cnt_q < LockW'(LOCK_MAX));
`endif

        case (state_q)
            S_IDLE: begin
                if (c_req | l_req) begin
                    grant_l = (c_req & l_req) ? rr_q : l_req;
`ifdef DMEM_ARB_LOCK_EN
                    if (lock_hit) grant_l = 1'b1;
                    if (!grant_l)     lock_cnt_d = '0;
                    else if (lock_hit) lock_cnt_d = lock_cnt_q + LockW'(1);
`endif
                    owner_d = grant_l;
                    we_d    = grant_l ? l_we    : c_we;
                    addr_d  = grant_l ? l_addr  : c_addr;
                    wdata_d = grant_l ? l_wdata : c_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_read  = ~we_q;
                mem_write = we_q;
                if (!we_q) begin
                    if (owner_q) l_rdata_d = mem_rdata;
                    else         c_rdata_d = mem_rdata;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                c_ack   = ~owner_q;
                l_ack   = owner_q;
                rr_d    = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DMEM_ARB_LOCK_EN
        if (!l_lock) lock_cnt_d = '0;
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            rr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
`ifdef DMEM_ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
            l_rdata_q <= l_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    // Memory strobes decode straight from state_q, so an async reset drops them in the same cycle.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign c_rdata   = c_rdata_q;
    assign l_rdata   = l_rdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != S_IDLE);
    assign c_stall   = c_req & ~c_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory attached.
module tb_dmem_arbiter;

    localparam int DW = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, c_ack, c_stall;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          l_req, l_we, l_ack;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic          mem_read, mem_write, owner, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_ack    (c_ack),
        .c_rdata  (c_rdata),
        .c_stall  (c_stall),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_ack    (l_ack),
        .l_rdata  (l_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .owner    (owner),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        rst = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;

        // Reset state
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_acks", {c_ack, l_ack}, 0);
        check("rst_c_rdata", c_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        step(); step();
        rst = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // C store addr 5 data 0xA5
        c_req = 1'b1; c_we = 1'b1; c_addr = 6'd5; c_wdata = 64'hA5;
        #1 check("t1_stall_pending", c_stall, 1);
        step();
        check("t1_acc_mem_write", mem_write, 1);
        check("t1_acc_mem_read", mem_read, 0);
        check("t1_acc_mem_addr", mem_addr, 5);
        check("t1_acc_c_ack", c_ack, 0);
        check("t1_acc_stall", c_stall, 1);
        check("t1_acc_busy", busy, 1);
        step();
        check("t1_resp_mem_write", mem_write, 0);
        check("t1_resp_c_ack", c_ack, 1);
        check("t1_resp_stall", c_stall, 0);
        check("t1_mem5", mem[5], 64'hA5);
        c_req = 1'b0;
        step();
        check("t1_idle_c_ack", c_ack, 0);
        check("t1_idle_busy", busy, 0);

        // C load addr 5
        c_req = 1'b1; c_we = 1'b0; c_addr = 6'd5; c_wdata = 64'hDEAD;
        step();
        check("t2_acc_mem_read", mem_read, 1);
        check("t2_acc_mem_write", mem_write, 0);
        check("t2_acc_mem_addr", mem_addr, 5);
        step();
        check("t2_resp_c_ack", c_ack, 1);
        check("t2_c_rdata", c_rdata, 64'hA5);
        check("t2_l_rdata", l_rdata, 0);
        c_req = 1'b0;
        step();

        // L store in flight, C load raised mid-transaction
        l_req = 1'b1; l_we = 1'b1; l_addr = 6'd9; l_wdata = 64'h1234;
        step();
        check("t5_acc_owner", owner, 1);
        check("t5_acc_mem_write", mem_write, 1);
        check("t5_acc_mem_addr", mem_addr, 9);
        c_req = 1'b1; c_we = 1'b0; c_addr = 6'd9;
        step();
        check("t5_l_ack", l_ack, 1);
        check("t5_c_ack_early", c_ack, 0);
        check("t5_stall", c_stall, 1);
        check("t5_c_rdata_kept", c_rdata, 64'hA5);
        l_req = 1'b0;
        step();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_c_ack", c_ack, 0);
        step();
        check("t5_c_acc_owner", owner, 0);
        check("t5_c_acc_read", mem_read, 1);
        check("t5_c_ack_early2", c_ack, 0);
        step();
        check("t5_c_ack", c_ack, 1);
        check("t5_c_rdata", c_rdata, 64'h1234);
        check("t5_l_rdata_kept", l_rdata, 0);
        c_req = 1'b0;
        step();

        // Reset asserted during ACCESS of an L store
        l_req = 1'b1; l_we = 1'b1; l_addr = 6'd3; l_wdata = 64'h77;
        step();
        check("t4_acc_mem_write", mem_write, 1);
        #1 rst = 1'b0;
        #1;
        check("t4_rst_mem_write", mem_write, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_owner", owner, 0);
        check("t4_rst_mem_addr", mem_addr, 0);
        check("t4_rst_c_rdata", c_rdata, 0);
        // Both ports load-request while reset is held
        l_we = 1'b0; l_addr = 6'd9;
        c_req = 1'b1; c_we = 1'b0; c_addr = 6'd5;
        step();
        check("t4_no_l_ack", l_ack, 0);
        step();
        check("t4_no_l_ack2", l_ack, 0);
        check("t4_mem3_unwritten", mem[3], 0);
        check("t4_hold_busy", busy, 0);
        rst = 1'b1;

        // Both requests held: grants alternate C, L, C, L with acks 3 cycles apart
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t3_c_ack_k%0d", k), c_ack, ((k % 6) == 2) ? 1 : 0);
            check($sformatf("t3_l_ack_k%0d", k), l_ack, ((k % 6) == 5) ? 1 : 0);
            check($sformatf("t3_owner_k%0d", k), owner, (((k - 1) / 3) % 2) ? 1 : 0);
            if (k == 2) check("t3_c_rdata", c_rdata, 64'hA5);
            if (k == 5) check("t3_l_rdata", l_rdata, 64'h1234);
        end
        c_req = 1'b0;
        l_req = 1'b0;
        step(); step();
        check("end_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
